// File: rtl/mem_arbiter_if.sv
// Bundle of requester, ready/data and memory-port signals around mem_arbiter.
// slave = arbiter view, master = requesters plus memory array view.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        imem_r;
  logic [15:0] instr;
  logic        d_req;
  logic [15:0] d_addr;
  logic [1:0]  d_we;
  logic [15:0] d_wdata;
  logic        dmem_r;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic [1:0]  mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
    output imem_r, instr, dmem_r, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
    input  imem_r, instr, dmem_r, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin on collisions; default is fixed data priority.
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        gnt_data_q;
  logic        live_q;
  logic        busy_q;
  logic        mem_en_q;
  logic [1:0]  mem_we_q;
  logic [14:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic        imem_r_q;
  logic        dmem_r_q;
  logic [15:0] instr_q;
  logic [15:0] d_rdata_q;
`ifdef MEM_ARB_RR_EN
  logic        last_gnt_data_q;
`endif

  logic        req_any_s;
  logic        gnt_data_d;
  logic        unused_addr_lsb_s;

  assign unused_addr_lsb_s = bus.if_addr[0] ^ bus.d_addr[0];

  // Arbitration: who would win if the FSM granted this cycle
  always_comb begin
    req_any_s = bus.if_req | bus.d_req;
`ifdef MEM_ARB_RR_EN
    if (bus.if_req && bus.d_req) begin
      gnt_data_d = ~last_gnt_data_q;
    end else begin
      gnt_data_d = bus.d_req;
    end
`else
    gnt_data_d = bus.d_req;
`endif
  end

  // Access sequencer with registered memory-port and ready outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      gnt_data_q  <= 1'b0;
      live_q      <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 2'b00;
      mem_addr_q  <= 15'h0000;
      mem_wdata_q <= 16'h0000;
      imem_r_q    <= 1'b0;
      dmem_r_q    <= 1'b0;
      instr_q     <= 16'h0000;
      d_rdata_q   <= 16'h0000;
`ifdef MEM_ARB_RR_EN
      last_gnt_data_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_any_s) begin
            state_q     <= S_BUSY;
            cnt_q       <= CNT_INIT;
            gnt_data_q  <= gnt_data_d;
            live_q      <= 1'b1;
            busy_q      <= 1'b1;
            mem_en_q    <= 1'b1;
            mem_addr_q  <= gnt_data_d ? bus.d_addr[15:1] : bus.if_addr[15:1];
            mem_we_q    <= gnt_data_d ? bus.d_we : 2'b00;
            mem_wdata_q <= gnt_data_d ? bus.d_wdata : 16'h0000;
`ifdef MEM_ARB_RR_EN
            last_gnt_data_q <= gnt_data_d;
`endif
          end
        end
        S_BUSY: begin
          // A fetch whose request drops mid-access is a branch redirect: finish silently
          if (!gnt_data_q && !bus.if_req) begin
            live_q <= 1'b0;
          end
          if (cnt_q == 4'd0) begin
            state_q     <= S_DONE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 2'b00;
            mem_addr_q  <= 15'h0000;
            mem_wdata_q <= 16'h0000;
            if (gnt_data_q) begin
              d_rdata_q <= bus.mem_rdata;
              dmem_r_q  <= 1'b1;
            end else begin
              instr_q  <= bus.mem_rdata;
              imem_r_q <= live_q & bus.if_req;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          imem_r_q <= 1'b0;
          dmem_r_q <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= 4'd0;
          busy_q      <= 1'b0;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 2'b00;
          mem_addr_q  <= 15'h0000;
          mem_wdata_q <= 16'h0000;
          imem_r_q    <= 1'b0;
          dmem_r_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_r    = imem_r_q;
  assign bus.instr     = instr_q;
  assign bus.dmem_r    = dmem_r_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule
